lcd_record_scheduler: RTL and testbench

- Sits between key_logic_fsm / the timer BCD bus and lcd_bridge.
- Captures lap snapshots into a small FIFO so that laps pressed while the LCD is still updating are not lost.
- Drains the FIFO into lcd_bridge one record at a time using an insert/busy handshake.
- Sequences clear requests, which take priority and flush the pending queue.

---
 rtl/lcd_record_scheduler.sv | 161 ++++++++++++++++
 tb/tb_lcd_record_scheduler.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_record_scheduler.sv
// lcd_record_scheduler: queues lap snapshots and feeds them to lcd_bridge one
// at a time over an insert/busy handshake; clear requests flush the queue and
// are sequenced to the LCD after any record already in flight.
module lcd_record_scheduler #(
  parameter int DEPTH       = 4,
  parameter int REC_W       = 32,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     lap_req,
  input  logic                     clear_req,
  input  logic [REC_W-1:0]         record_in,
  input  logic                     lcd_busy,
  output logic                     lcd_insert,
  output logic [REC_W-1:0]         lcd_record,
  output logic                     lcd_clear,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     overflow,
  output logic                     sched_busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  // Last timer value seen while waiting for busy before giving up on the ack
  localparam logic [3:0] ACK_LAST = 4'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_ACK,
    WAIT_DONE,
    GAP
  } state_t;

  state_t            state_q;
  logic [3:0]        timer_q;
  logic [AW-1:0]     wrPtr_q, wrPtr_d;
  logic [AW-1:0]     rdPtr_q, rdPtr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              pendingClear_q, pendingClear_d;
  logic              lcdInsert_q;
  logic              lcdClear_q;
  logic [REC_W-1:0]  lcdRecord_q;
  logic [REC_W-1:0]  mem_q [DEPTH];

  logic              isFull;
  logic              pushOk;
  logic              issueClear;
  logic              issueInsert;
  logic [REC_W-1:0]  headData;

  // Queue bookkeeping: push/pop decisions and next pointer/count/flag values.
  // An empty queue forwards record_in straight through so a lap reaches the
  // LCD on the very next cycle; a clear wipes everything including that lap.
  always_comb begin
    isFull      = (count_q == CW'(DEPTH));
    pushOk      = lap_req && !clear_req && !isFull;
    issueClear  = (state_q == IDLE) && pendingClear_q && !lcd_busy;
    issueInsert = (state_q == IDLE) && !pendingClear_q && !clear_req && !lcd_busy &&
                  ((count_q != '0) || pushOk);
    headData    = (count_q == '0) ? record_in : mem_q[rdPtr_q];

    wrPtr_d        = wrPtr_q;
    rdPtr_d        = rdPtr_q;
    count_d        = count_q;
    overflow_d     = overflow_q;
    pendingClear_d = pendingClear_q;

    if (clear_req) begin
      wrPtr_d        = '0;
      rdPtr_d        = '0;
      count_d        = '0;
      overflow_d     = 1'b0;
      pendingClear_d = 1'b1;
    end else begin
      if (pushOk) wrPtr_d = wrPtr_q + AW'(1);
      if (issueInsert) rdPtr_d = rdPtr_q + AW'(1);
      count_d = count_q + CW'(pushOk) - CW'(issueInsert);
      if (lap_req && isFull) overflow_d = 1'b1;
      if (issueClear) pendingClear_d = 1'b0;
    end
  end

  // Record storage; contents need no reset because count guards every read.
  always_ff @(posedge clock) begin
    if (pushOk) mem_q[wrPtr_q] <= record_in;
  end

  // Register the queue pointers, occupancy and sticky flags.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wrPtr_q        <= '0;
      rdPtr_q        <= '0;
      count_q        <= '0;
      overflow_q     <= 1'b0;
      pendingClear_q <= 1'b0;
    end else begin
      wrPtr_q        <= wrPtr_d;
      rdPtr_q        <= rdPtr_d;
      count_q        <= count_d;
      overflow_q     <= overflow_d;
      pendingClear_q <= pendingClear_d;
    end
  end

  // Command sequencer: issue a clear or insert, wait for the bridge to take it
  // (or time out), wait for it to finish, then leave one quiet cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      lcdInsert_q <= 1'b0;
      lcdClear_q  <= 1'b0;
      lcdRecord_q <= '0;
    end else begin
      lcdInsert_q <= 1'b0;
      lcdClear_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (issueClear) begin
            lcdClear_q <= 1'b1;
            timer_q    <= '0;
            state_q    <= WAIT_ACK;
          end else if (issueInsert) begin
            lcdInsert_q <= 1'b1;
            lcdRecord_q <= headData;
            timer_q     <= '0;
            state_q     <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (lcd_busy) begin
            state_q <= WAIT_DONE;
          end else if (timer_q == ACK_LAST) begin
            state_q <= IDLE;
          end else begin
            timer_q <= timer_q + 4'd1;
          end
        end
        WAIT_DONE: begin
          if (!lcd_busy) state_q <= GAP;
        end
        GAP: begin
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign lcd_insert = lcdInsert_q;
  assign lcd_clear  = lcdClear_q;
  assign lcd_record = lcdRecord_q;
  assign count      = count_q;
  assign full       = isFull;
  assign overflow   = overflow_q;
  assign sched_busy = (state_q != IDLE) || (count_q != '0);

endmodule

// File: tb/tb_lcd_record_scheduler.sv
// Testbench for lcd_record_scheduler: fixed vector table, directed corner
// sequences and a randomized run against a queue-based reference model.
module tb_lcd_record_scheduler;

  localparam int DEPTH       = 4;
  localparam int REC_W       = 32;
  localparam int ACK_TIMEOUT = 15;

  logic              clock;
  logic              reset_n;
  logic              lap_req;
  logic              clear_req;
  logic [REC_W-1:0]  record_in;
  logic              lcd_busy;
  logic              lcd_insert;
  logic [REC_W-1:0]  lcd_record;
  logic              lcd_clear;
  logic [2:0]        count;
  logic              full;
  logic              overflow;
  logic              sched_busy;

  int total = 0;
  int bad   = 0;

  lcd_record_scheduler #(
    .DEPTH(DEPTH),
    .REC_W(REC_W),
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .lap_req(lap_req),
    .clear_req(clear_req),
    .record_in(record_in),
    .lcd_busy(lcd_busy),
    .lcd_insert(lcd_insert),
    .lcd_record(lcd_record),
    .lcd_clear(lcd_clear),
    .count(count),
    .full(full),
    .overflow(overflow),
    .sched_busy(sched_busy)
  );

  // Free-running clock, period 10
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Reference model: pending records as a queue, a command described by
  // "running", "bridge has shown busy", a no-ack cycle count and a cooldown.
  logic [REC_W-1:0] mQ[$];
  bit               mRunning, mSawBusy, mCooldown, mPend, mOvf, mIns, mClr;
  int               mNoAck;
  logic [REC_W-1:0] mRec;

  task automatic modelReset();
    mQ.delete();
    mRunning = 0; mSawBusy = 0; mCooldown = 0; mPend = 0; mOvf = 0;
    mIns = 0; mClr = 0; mNoAck = 0; mRec = '0;
  endtask

  task automatic modelStep(input bit lap, input bit clr, input logic [REC_W-1:0] rec, input bit busy);
    bit quiet;
    quiet = !mRunning && !mCooldown;
    mIns = 0;
    mClr = 0;
    if (mRunning && !mSawBusy) begin
      if (busy) mSawBusy = 1;
      else begin
        mNoAck++;
        if (mNoAck == ACK_TIMEOUT) mRunning = 0;
      end
    end else if (mRunning) begin
      if (!busy) begin
        mRunning = 0;
        mCooldown = 1;
      end
    end else if (mCooldown) begin
      mCooldown = 0;
    end
    if (lap && !clr && mQ.size() == DEPTH) mOvf = 1;
    if (lap && !clr && mQ.size() < DEPTH) mQ.push_back(rec);
    if (quiet && !busy) begin
      if (mPend) begin
        mClr = 1;
        mPend = 0;
        mRunning = 1; mSawBusy = 0; mNoAck = 0;
      end else if (!clr && mQ.size() > 0) begin
        mIns = 1;
        mRec = mQ.pop_front();
        mRunning = 1; mSawBusy = 0; mNoAck = 0;
      end
    end
    if (clr) begin
      mQ.delete();
      mOvf = 0;
      mPend = 1;
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compareModel();
    checkOutput("insert", 32'(lcd_insert), 32'(mIns));
    checkOutput("clear", 32'(lcd_clear), 32'(mClr));
    checkOutput("record", lcd_record, mRec);
    checkOutput("count", 32'(count), 32'(mQ.size()));
    checkOutput("full", 32'(full), 32'(mQ.size() == DEPTH));
    checkOutput("overflow", 32'(overflow), 32'(mOvf));
    checkOutput("sched_busy", 32'(sched_busy), 32'(mRunning || mCooldown || mQ.size() > 0));
  endtask

  // One clock cycle: drive inputs, clock, advance the model, compare at edge+1
  task automatic applyStimulus(input bit lap, input bit clr, input logic [REC_W-1:0] rec, input bit busy);
    lap_req = lap;
    clear_req = clr;
    record_in = rec;
    lcd_busy = busy;
    @(posedge clock);
    modelStep(lap, clr, rec, busy);
    #1;
    compareModel();
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_insert"}, 32'(lcd_insert), 0);
    checkOutput({tag, "_clear"}, 32'(lcd_clear), 0);
    checkOutput({tag, "_record"}, lcd_record, 0);
    checkOutput({tag, "_count"}, 32'(count), 0);
    checkOutput({tag, "_full"}, 32'(full), 0);
    checkOutput({tag, "_overflow"}, 32'(overflow), 0);
    checkOutput({tag, "_sched_busy"}, 32'(sched_busy), 0);
  endtask

  task automatic doReset();
    reset_n = 1'b0;
    lap_req = 0; clear_req = 0; record_in = '0; lcd_busy = 0;
    @(posedge clock);
    @(posedge clock);
    #1;
    checkAllZero("reset");
    reset_n = 1'b1;
    modelReset();
  endtask

  typedef struct {
    logic             lap;
    logic [REC_W-1:0] rec;
    logic             busy;
    logic             eIns;
    logic [REC_W-1:0] eRec;
    logic [2:0]       eCnt;
    logic             eFull;
    logic             eOvf;
    logic             eSb;
  } vec_t;

  function automatic vec_t mk(logic lap, logic [REC_W-1:0] rec, logic busy, logic eIns,
                              logic [REC_W-1:0] eRec, logic [2:0] eCnt, logic eFull, logic eOvf, logic eSb);
    vec_t v;
    v.lap = lap; v.rec = rec; v.busy = busy; v.eIns = eIns; v.eRec = eRec;
    v.eCnt = eCnt; v.eFull = eFull; v.eOvf = eOvf; v.eSb = eSb;
    return v;
  endfunction

  vec_t vecs[13];

  initial begin
    logic [REC_W-1:0] got[$];
    int sinceIns;
    int nIns, nClr, firstAt, secondAt;
    bit busyR;

    // Busy held while five laps arrive, then the bridge drains them
    vecs[0]  = mk(1, 32'd1, 1, 0, 32'd0, 3'd1, 0, 0, 1);
    vecs[1]  = mk(1, 32'd2, 1, 0, 32'd0, 3'd2, 0, 0, 1);
    vecs[2]  = mk(1, 32'd3, 1, 0, 32'd0, 3'd3, 0, 0, 1);
    vecs[3]  = mk(1, 32'd4, 1, 0, 32'd0, 3'd4, 1, 0, 1);
    vecs[4]  = mk(1, 32'd5, 1, 0, 32'd0, 3'd4, 1, 1, 1);
    vecs[5]  = mk(0, 32'd0, 1, 0, 32'd0, 3'd4, 1, 1, 1);
    vecs[6]  = mk(0, 32'd0, 0, 1, 32'd1, 3'd3, 0, 1, 1);
    vecs[7]  = mk(0, 32'd0, 0, 0, 32'd1, 3'd3, 0, 1, 1);
    vecs[8]  = mk(0, 32'd0, 1, 0, 32'd1, 3'd3, 0, 1, 1);
    vecs[9]  = mk(0, 32'd0, 1, 0, 32'd1, 3'd3, 0, 1, 1);
    vecs[10] = mk(0, 32'd0, 0, 0, 32'd1, 3'd3, 0, 1, 1);
    vecs[11] = mk(0, 32'd0, 0, 0, 32'd1, 3'd3, 0, 1, 1);
    vecs[12] = mk(0, 32'd0, 0, 1, 32'd2, 3'd2, 0, 1, 1);

    doReset();
    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i].lap, 0, vecs[i].rec, vecs[i].busy);
      checkOutput($sformatf("vec%0d_insert", i), 32'(lcd_insert), 32'(vecs[i].eIns));
      checkOutput($sformatf("vec%0d_record", i), lcd_record, vecs[i].eRec);
      checkOutput($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].eCnt));
      checkOutput($sformatf("vec%0d_full", i), 32'(full), 32'(vecs[i].eFull));
      checkOutput($sformatf("vec%0d_overflow", i), 32'(overflow), 32'(vecs[i].eOvf));
      checkOutput($sformatf("vec%0d_sched_busy", i), 32'(sched_busy), 32'(vecs[i].eSb));
    end
    // Remaining records drain through a bridge that acks two cycles after insert
    sinceIns = 0;
    for (int c = 0; c < 80; c++) begin
      busyR = (sinceIns >= 2 && sinceIns < 5);
      applyStimulus(0, 0, '0, busyR);
      if (lcd_insert) begin
        got.push_back(lcd_record);
        sinceIns = 0;
      end else begin
        sinceIns++;
      end
    end
    checkOutput("drain_count", 32'(got.size()), 2);
    if (got.size() == 2) begin
      checkOutput("drain_rec3", got[0], 32'd3);
      checkOutput("drain_rec4", got[1], 32'd4);
    end

    // Single lap latency and sched_busy release after the bridge finishes
    doReset();
    applyStimulus(1, 0, 32'h0012_3456, 0);
    checkOutput("lat_insert", 32'(lcd_insert), 1);
    checkOutput("lat_record", lcd_record, 32'h0012_3456);
    applyStimulus(0, 0, '0, 0);
    checkOutput("lat_insert_one_cycle", 32'(lcd_insert), 0);
    for (int c = 0; c < 20; c++) applyStimulus(0, 0, '0, 1);
    applyStimulus(0, 0, '0, 0);
    checkOutput("lat_sb_gap", 32'(sched_busy), 1);
    applyStimulus(0, 0, '0, 0);
    checkOutput("lat_sb_idle", 32'(sched_busy), 0);

    // Clear while a record is in flight with two more queued
    doReset();
    applyStimulus(1, 0, 32'hA, 0);
    applyStimulus(0, 0, '0, 1);
    applyStimulus(1, 0, 32'hB, 1);
    applyStimulus(1, 0, 32'hC, 1);
    checkOutput("clr_pre_count", 32'(count), 2);
    applyStimulus(0, 1, '0, 1);
    checkOutput("clr_count", 32'(count), 0);
    checkOutput("clr_overflow", 32'(overflow), 0);
    nIns = 0; nClr = 0;
    for (int c = 0; c < 3; c++) applyStimulus(0, 0, '0, 1);
    for (int c = 0; c < 30; c++) begin
      applyStimulus(0, 0, '0, 0);
      nIns += int'(lcd_insert);
      nClr += int'(lcd_clear);
    end
    checkOutput("clr_pulses", 32'(nClr), 1);
    checkOutput("clr_no_insert", 32'(nIns), 0);

    // Lap and clear on the same edge with an empty queue
    doReset();
    applyStimulus(1, 1, 32'h77, 0);
    checkOutput("same_count", 32'(count), 0);
    nIns = 0; nClr = 0;
    for (int c = 0; c < 25; c++) begin
      applyStimulus(0, 0, '0, 0);
      nIns += int'(lcd_insert);
      nClr += int'(lcd_clear);
    end
    checkOutput("same_clear", 32'(nClr), 1);
    checkOutput("same_no_insert", 32'(nIns), 0);

    // Bridge never acknowledges: the next record follows after the timeout
    doReset();
    applyStimulus(1, 0, 32'h11, 1);
    applyStimulus(1, 0, 32'h22, 1);
    firstAt = -1; secondAt = -1;
    for (int c = 0; c < 60; c++) begin
      applyStimulus(0, 0, '0, 0);
      if (lcd_insert && firstAt < 0) firstAt = c;
      else if (lcd_insert && secondAt < 0) secondAt = c;
    end
    checkOutput("to_first_at", 32'(firstAt), 0);
    checkOutput("to_gap", 32'(secondAt - firstAt), ACK_TIMEOUT + 1);
    checkOutput("to_record", lcd_record, 32'h22);

    // Asynchronous reset during WAIT_DONE with three entries queued
    doReset();
    applyStimulus(1, 0, 32'h1, 0);
    applyStimulus(0, 0, '0, 1);
    applyStimulus(1, 0, 32'h2, 1);
    applyStimulus(1, 0, 32'h3, 1);
    applyStimulus(1, 0, 32'h4, 1);
    checkOutput("ar_pre_count", 32'(count), 3);
    #2 reset_n = 1'b0;
    #1;
    checkAllZero("async");
    @(posedge clock);
    #1;
    lap_req = 0; clear_req = 0; lcd_busy = 0;
    reset_n = 1'b1;
    modelReset();
    nIns = 0;
    for (int c = 0; c < 30; c++) begin
      applyStimulus(0, 0, '0, 0);
      nIns += int'(lcd_insert);
    end
    checkOutput("ar_no_insert", 32'(nIns), 0);

    // Randomized traffic against the reference model
    doReset();
    busyR = 0;
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 99) < 25) busyR = !busyR;
      applyStimulus($urandom_range(0, 99) < 35, $urandom_range(0, 99) < 4, $urandom, busyR);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
